uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
- Upstream framing stage between the UART receiver and the command/register control logic.
- Assembles received bytes into 4-byte command frames, MSB byte first. Frame layout: byte0 = command (bit0 = write flag), byte1 = register address, byte2/byte3 = data high/low.
- Drops partial frames on an inter-byte timeout. Holds one complete frame in an output register and releases it with a valid/ready handshake.

Parameters:
- TIMEOUT_CLKS, 7440, clocks of rx_dv inactivity inside a partial frame before it is discarded. Default is 4 byte-times at 186 clk/bit.
- CNT_W, 13, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CLKS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- rx_dv  input  1  one-clock strobe from the UART receiver: rx_byte is valid this cycle.
- rx_byte  input  8  received byte.
- frm_valid  output  1  complete frame held on frm_* outputs.
- frm_ready  input  1  consumer accepts the frame; transfer occurs when frm_valid and frm_ready are both high.
- frm_wr  output  1  byte0 bit0 of the held frame.
- frm_addr  output  8  byte1 of the held frame.
- frm_data  output  16  {byte2, byte3} of the held frame.
- frm_raw  output  32  {byte0, byte1, byte2, byte3} of the held frame.
- busy  output  1  partial frame in progress (state COLLECT).
- to_err  output  1  one-clock pulse: partial frame discarded by timeout.
- ovf_err  output  1  one-clock pulse: completed frame dropped because the output slot was occupied.

Behaviour:
- Reset (rst=0, async): state IDLE; byte count 0; shift register 0; timer 0.
- Reset values of outputs: frm_valid=0, frm_raw=0 (so frm_wr/frm_addr/frm_data=0), busy=0, to_err=0, ovf_err=0.
- Reset mid-frame or mid-handshake discards everything immediately. Registers leave reset on the first clk edge after rst=1.
- FSM states: IDLE, COLLECT.
  - IDLE: on rx_dv, shift in byte, count=1, timer=0, go to COLLECT.
  - COLLECT: each rx_dv shifts the byte into bits [7:0] (older bytes move up 8) and increments count.
  - COLLECT, no rx_dv: timer increments. When timer == TIMEOUT_CLKS-1, discard the partial frame, count=0, pulse to_err next cycle, go to IDLE.
- Priority: rx_dv on the same cycle the timer expires is accepted. The timer clears and there is no to_err.
- Frame completion: the 4th rx_dv completes the frame. Next cycle the state is IDLE, count=0, busy=0.
  - Slot free, or slot being drained this cycle (frm_valid & frm_ready): load frm_raw with the 4 bytes and set frm_valid=1 on the following edge. Latency is 1 clk from the 4th rx_dv.
  - Slot occupied and not draining: drop the frame, frm_* unchanged, ovf_err=1 for one cycle.
- Handshake: frm_* outputs are stable while frm_valid=1 and frm_ready=0. On transfer, frm_valid clears next cycle unless reloaded the same cycle. frm_ready while frm_valid=0 is ignored.
- Frame collection continues regardless of the output slot state. Back-to-back rx_dv on consecutive cycles must be accepted.
- Count is 2 bits and wraps 3→0 only through completion. Timer saturates; it never wraps.

Test Plan:
- Basic frame: frm_ready=1, rx bytes 0x01,0x00,0x01,0x23 spaced 1860 clk → 1 clk after 4th rx_dv: frm_valid=1, frm_wr=1, frm_addr=0x00, frm_data=0x0123, frm_raw=0x01000123, one-cycle valid pulse.
- Backpressure: frm_ready=0; frame A=0x00112233, then frame B=0x01445566 → A held stable, ovf_err pulses 1 clk after B's 4th byte. Raise frm_ready → A transferred, frm_valid=0 next cycle.
- Simultaneous drain/reload: frame A held; frm_ready=1 on the same cycle as B's 4th rx_dv → frm_valid stays 1, frm_raw=B, no ovf_err.
- Timeout: 2 bytes then idle TIMEOUT_CLKS clocks → to_err single pulse, busy=0. Next 4 bytes 0xAA,0xBB,0xCC,0xDD → frm_raw=0xAABBCCDD.
- Timeout boundary: byte arrives exactly on the expiry cycle → no to_err, frame completes normally.
- Async reset: drop rst mid-frame (2 bytes in) with frm_valid=1 → all outputs 0 without a clock edge. After release, a fresh 4-byte frame is captured correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_rx
//  Description : Collects UART receive bytes into 4-byte command frames,
//                sent MSB byte first: byte0 = command (bit0 = write flag),
//                byte1 = register address, byte2/byte3 = data high/low.
//                A partial frame is discarded after TIMEOUT_CLKS clocks
//                without a byte. One complete frame is held in an output
//                register and released with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    rst        in   asynchronous reset, active-low (0 = reset)
//    rx_dv      in   one-clock strobe, rx_byte valid
//    rx_byte    in   [7:0] received byte
//    frm_valid  out  complete frame held on frm_* outputs
//    frm_ready  in   consumer accepts the held frame
//    frm_wr     out  byte0 bit0 of the held frame
//    frm_addr   out  [7:0]  byte1 of the held frame
//    frm_data   out  [15:0] {byte2, byte3} of the held frame
//    frm_raw    out  [31:0] {byte0, byte1, byte2, byte3}
//    busy       out  partial frame in progress
//    to_err     out  one-clock pulse, partial frame discarded by timeout
//    ovf_err    out  one-clock pulse, completed frame dropped (slot full)
// ============================================================================
module uart_frame_rx #(
  parameter int TIMEOUT_CLKS = 7440,
  parameter int CNT_W        = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic        frm_wr,
  output logic [7:0]  frm_addr,
  output logic [15:0] frm_data,
  output logic [31:0] frm_raw,
  output logic        busy,
  output logic        to_err,
  output logic        ovf_err
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] c_TO_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  // Only the three earlier bytes need storage; the 4th is taken straight
  // from rx_byte on the completing cycle.
  logic [23:0]      r_shift;
  logic [23:0]      w_shift_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic             w_done;
  logic             w_to;
  logic             w_slot_free;
  logic [31:0]      w_frame;

  logic             r_frm_valid;
  logic [31:0]      r_frm_raw;
  logic             r_to_err;
  logic             r_ovf_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_timer_nxt = r_timer;
    w_done      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_dv) begin
          w_shift_nxt = {r_shift[15:0], rx_byte};
          w_cnt_nxt   = 2'd1;
          w_timer_nxt = '0;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A byte on the expiry cycle wins over the timeout.
        if (rx_dv) begin
          w_timer_nxt = '0;
          if (r_cnt == 2'd3) begin
            w_done      = 1'b1;
            w_cnt_nxt   = 2'd0;
            w_shift_nxt = 24'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_shift_nxt = {r_shift[15:0], rx_byte};
            w_cnt_nxt   = r_cnt + 2'd1;
          end
        end else if (r_timer == c_TO_LAST) begin
          w_to        = 1'b1;
          w_cnt_nxt   = 2'd0;
          w_shift_nxt = 24'd0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (r_timer != c_TO_MAX) begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
        w_shift_nxt = 24'd0;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign w_frame     = {r_shift, rx_byte};
  // The slot may be refilled on the same cycle the consumer drains it.
  assign w_slot_free = !r_frm_valid || frm_ready;

  // Output slot and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frm_valid <= 1'b0;
      r_frm_raw   <= 32'd0;
      r_to_err    <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_to_err  <= w_to;
      r_ovf_err <= w_done && !w_slot_free;
      if (w_done && w_slot_free) begin
        r_frm_raw   <= w_frame;
        r_frm_valid <= 1'b1;
      end else if (r_frm_valid && frm_ready) begin
        r_frm_valid <= 1'b0;
      end
    end
  end

  assign frm_valid = r_frm_valid;
  assign frm_raw   = r_frm_raw;
  assign frm_wr    = r_frm_raw[24];
  assign frm_addr  = r_frm_raw[23:16];
  assign frm_data  = r_frm_raw[15:0];
  assign busy      = (r_state == S_COLLECT);
  assign to_err    = r_to_err;
  assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire
